// File: rtl/axi_slv_mem.sv
// AXI slave memory responder: independent read/write burst engines over a
// word-addressed, byte-strobed register array (FIXED/INCR/WRAP, up to 256 beats).
module axi_slv_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int NBL = $clog2(NB);
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic illegal(input logic [1:0] burst, input logic [2:0] size,
                                   input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || (int'(size) > NBL) || bad_wrap;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] one, bytes, span;
    one   = ADDR_WIDTH'(1);
    bytes = one << size;
    span  = (ADDR_WIDTH'(len) + one) * bytes;
    case (burst)
      2'b01:   return (addr & ~(bytes - one)) + bytes;
      2'b10:   return (addr & ~(span - one)) | ((addr + bytes) & (span - one));
      default: return addr;
    endcase
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> NBL) < ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  // ---------------- write engine ----------------
  logic [1:0]            w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  w_beat, w_bad, w_at_len, w_final;
  logic [IW-1:0]         w_idx;

  always_comb begin
    w_beat   = (w_state == W_DATA) && wvalid;
    w_at_len = (w_cnt == w_len);
    w_final  = wlast || w_at_len;
    w_bad    = illegal(w_burst, w_size, w_len) || !in_range(w_addr) || (wid != w_id);
    w_idx    = IW'(w_addr >> NBL);
  end

  assign awready = (w_state == W_IDLE);
  assign wready  = (w_state == W_DATA);
  assign bvalid  = (w_state == W_RESP);
  assign bid     = bvalid ? w_id : '0;
  assign bresp   = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_id    <= awid;
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= '0;
          w_err   <= 1'b0;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          // early or missing wlast still ends the burst, but poisons the response
          w_err  <= w_err | w_bad | (wlast != w_at_len);
          if (w_final) w_state <= W_RESP;
        end
        W_RESP: if (bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_beat && !w_bad) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  logic [0:0]            r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_next, f_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  f_bad;
  logic [IW-1:0]         f_idx;

  // fetch address is the incoming AR in idle, otherwise the following beat
  always_comb begin
    r_next = next_addr(r_addr, r_size, r_len, r_burst);
    f_addr = (r_state == R_IDLE) ? araddr : r_next;
    f_bad  = ((r_state == R_IDLE) ? illegal(arburst, arsize, arlen)
                                  : illegal(r_burst, r_size, r_len)) || !in_range(f_addr);
    f_idx  = IW'(f_addr >> NBL);
  end

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_DATA);
  assign rid     = rvalid ? r_id : '0;
  assign rlast   = rvalid && (r_cnt == r_len);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_id    <= arid;
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= '0;
          rdata   <= f_bad ? '0 : mem[f_idx];
          rresp   <= f_bad ? RESP_SLVERR : RESP_OKAY;
          r_state <= R_DATA;
        end
        R_DATA: if (rready) begin
          if (rlast) begin
            r_state <= R_IDLE;
          end else begin
            r_addr <= r_next;
            r_cnt  <= r_cnt + 8'd1;
            rdata  <= f_bad ? '0 : mem[f_idx];
            rresp  <= f_bad ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem: a byte-level reference memory predicts every
// B and R beat; a monitor compares whatever the DUT presents against the queues.
module tb_axi_slv_mem;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IDW = 8;
  localparam int DEPTH = 64;
  localparam int LIM = 400;

  logic            aclk, aresetn;
  logic [IDW-1:0]  awid, wid, bid, arid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic            arvalid, arready, rlast, rvalid, rready;

  axi_slv_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .MEM_DEPTH(DEPTH)) u_dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed { logic [7:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [7:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  int          compared = 0;
  int          mismatched = 0;
  int          b_pops = 0;
  int          r_pops = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic ill(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    return (b == 2'b11) || (s > 3'd2) ||
           (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  // Byte address of beat i, from the burst definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] l,
                                            input logic [2:0] s, input logic [1:0] b, input int i);
    logic [31:0] bytes, span, base;
    bytes = 32'd1 << s;
    if (b == 2'b00 || i == 0) return a;
    if (b == 2'b01) return (a & ~(bytes - 32'd1)) + 32'(i) * bytes;
    span = (32'(l) + 32'd1) * bytes;
    base = a - (a % span);
    return base + (((a - base) + 32'(i) * bytes) % span);
  endfunction

  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (aresetn === 1'b1) begin
        if (bvalid === 1'b1) begin
          compared++;
          if (bq.size() == 0) begin
            mismatched++;
            $display("FAIL b_unexpected: got id=%0h resp=%0d expected none", bid, bresp);
          end else begin
            if (bid !== bq[0].id || bresp !== bq[0].resp) begin
              mismatched++;
              $display("FAIL b_resp: got id=%0h resp=%0d expected id=%0h resp=%0d",
                       bid, bresp, bq[0].id, bq[0].resp);
            end
            if (bready) begin void'(bq.pop_front()); b_pops++; end
          end
        end
        if (rvalid === 1'b1) begin
          compared++;
          if (rq.size() == 0) begin
            mismatched++;
            $display("FAIL r_unexpected: got id=%0h data=%0h expected none", rid, rdata);
          end else begin
            if (rid !== rq[0].id || rdata !== rq[0].data || rresp !== rq[0].resp ||
                rlast !== rq[0].last) begin
              mismatched++;
              $display("FAIL r_beat: got id=%0h data=%0h resp=%0d last=%0b expected id=%0h data=%0h resp=%0d last=%0b",
                       rid, rdata, rresp, rlast, rq[0].id, rq[0].data, rq[0].resp, rq[0].last);
            end
            if (rready) begin void'(rq.pop_front()); r_pops++; end
          end
        end
      end
    end
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                          input logic [7:0] wid_v, input int bdelay);
    int n, t, target;
    logic err, bad, il;
    logic [31:0] a;
    n   = (wlast_at < int'(len)) ? wlast_at + 1 : int'(len) + 1;
    il  = ill(burst, size, len);
    err = (wlast_at != int'(len));
    for (int i = 0; i < n; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      bad = il || ((a >> 2) >= DEPTH) || (wid_v != id);
      err = err | bad;
      if (!bad)
        for (int j = 0; j < 4; j++)
          if (ws[i][j]) ref_mem[a >> 2][j*8 +: 8] = wd[i][j*8 +: 8];
    end
    bq.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!awready && t < LIM);
    chk("aw_handshake", 64'(awready), 64'd1);
    @(posedge aclk); #1 awvalid = 1'b0;

    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge aclk); #1; end
      wid = wid_v; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlast_at); wvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!wready && t < LIM);
      if (!wready) chk("w_handshake", 64'(wready), 64'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;

    t = 0;
    while (!bvalid && t < LIM) begin @(posedge aclk); #1; t++; end
    chk("b_latency", 64'(t), 64'd0);
    repeat (bdelay) begin @(posedge aclk); #1; end
    target = b_pops + 1;
    bready = 1'b1;
    t = 0;
    while (b_pops < target && t < LIM) begin @(posedge aclk); #1; t++; end
    bready = 1'b0;
    chk("b_done", 64'(b_pops), 64'(target));
  endtask

  task automatic push_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats);
    logic bad, il;
    logic [31:0] a;
    il = ill(burst, size, len);
    for (int i = 0; i < nbeats; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      bad = il || ((a >> 2) >= DEPTH);
      rq.push_back('{id: id, data: bad ? 32'd0 : ref_mem[a >> 2],
                     resp: bad ? 2'b10 : 2'b00, last: (i == int'(len))});
    end
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!arready && t < LIM);
    chk("ar_handshake", 64'(arready), 64'd1);
    @(posedge aclk); #1 arvalid = 1'b0;
  endtask

  // mode 0: rready held high, 1: toggling, 2: random
  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    int t, target;
    push_read(id, addr, len, size, burst, int'(len) + 1);
    target = r_pops + int'(len) + 1;
    send_ar(id, addr, len, size, burst);
    t = 0;
    while (r_pops < target && t < 3000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (t % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(posedge aclk); #1; t++;
    end
    rready = 1'b0;
    chk("r_done", 64'(r_pops), 64'(target));
  endtask

  task automatic fill_incr(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin wd[i] = base + 32'(i); ws[i] = 4'hF; end
  endtask

  initial begin
    int t, target;
    logic [7:0] id, len, widv;
    logic [2:0] size;
    logic [1:0] burst;
    logic [31:0] addr;
    int wl;

    aresetn = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    fork monitor(); join_none

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
    chk("rst_rid_rresp_rdata", 64'({rid, rresp, rdata}), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // initialise the whole array so every later read has a defined reference
    for (int i = 0; i < DEPTH; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(8'h01, 32'h0, 8'(DEPTH - 1), 3'd2, 2'b01, DEPTH - 1, 8'h01, 0);

    // INCR write then read
    fill_incr(4, 32'hA0);
    do_write(8'h11, 32'h10, 8'd3, 3'd2, 2'b01, 3, 8'h11, 0);
    do_read(8'h12, 32'h10, 8'd3, 3'd2, 2'b01, 0);

    // WRAP 0x18 -> 0x1C, 0x10, 0x14
    fill_incr(4, 32'hB0);
    do_write(8'h21, 32'h18, 8'd3, 3'd2, 2'b10, 3, 8'h21, 1);
    do_read(8'h22, 32'h18, 8'd3, 3'd2, 2'b10, 0);
    do_read(8'h23, 32'h10, 8'd3, 3'd2, 2'b01, 0);

    // strobes on a FIXED burst
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(8'h31, 32'h0, 8'd0, 3'd2, 2'b01, 0, 8'h31, 0);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0001;
    wd[1] = 32'hFFFFFFFF; ws[1] = 4'b1000;
    do_write(8'h32, 32'h0, 8'd1, 3'd2, 2'b00, 1, 8'h32, 0);
    do_read(8'h33, 32'h0, 8'd0, 3'd2, 2'b01, 0);

    // error cases: out of range, reserved burst, early wlast, missing wlast, wrong wid, bad wrap len
    fill_incr(4, 32'hEE00);
    do_write(8'h41, 32'(DEPTH * 4), 8'd0, 3'd2, 2'b01, 0, 8'h41, 0);
    do_write(8'h42, 32'h20, 8'd1, 3'd2, 2'b11, 1, 8'h42, 0);
    do_write(8'h43, 32'h40, 8'd3, 3'd2, 2'b01, 1, 8'h43, 0);
    do_write(8'h44, 32'h50, 8'd1, 3'd2, 2'b01, 9, 8'h44, 0);
    do_write(8'h45, 32'h60, 8'd1, 3'd2, 2'b01, 1, 8'h99, 0);
    do_write(8'h46, 32'h70, 8'd2, 3'd2, 2'b10, 2, 8'h46, 0);
    do_read(8'h47, 32'h20, 8'd1, 3'd2, 2'b01, 0);
    do_read(8'h48, 32'h40, 8'd3, 3'd2, 2'b01, 0);
    do_read(8'h49, 32'h60, 8'd1, 3'd2, 2'b01, 0);
    do_read(8'h4A, 32'(DEPTH * 4 - 8), 8'd3, 3'd2, 2'b01, 0);
    do_read(8'h4B, 32'h20, 8'd1, 3'd2, 2'b11, 0);

    // backpressure
    fill_incr(8, 32'hC0);
    do_write(8'h51, 32'h80, 8'd7, 3'd2, 2'b01, 7, 8'h51, 5);
    do_read(8'h52, 32'h80, 8'd7, 3'd2, 2'b01, 1);

    // simultaneous AW and AR to disjoint words
    fill_incr(2, 32'hD0);
    fork
      do_write(8'h61, 32'hA0, 8'd1, 3'd2, 2'b01, 1, 8'h61, 0);
      do_read(8'h62, 32'h80, 8'd3, 3'd2, 2'b01, 0);
    join
    do_read(8'h63, 32'hA0, 8'd1, 3'd2, 2'b01, 2);

    // reset in the middle of a read burst
    push_read(8'h71, 32'h0, 8'd7, 3'd2, 2'b01, 2);
    target = r_pops + 2;
    send_ar(8'h71, 32'h0, 8'd7, 3'd2, 2'b01);
    rready = 1'b1;
    t = 0;
    while (r_pops < target && t < LIM) begin @(posedge aclk); #1; t++; end
    rready = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd1);
    chk("midrst_rlast", 64'(rlast), 64'd0);
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    do_read(8'h72, 32'h14, 8'd0, 3'd2, 2'b01, 0);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      id    = 8'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (burst == 2'b10) begin
        case ($urandom_range(0, 4))
          0: len = 8'd1; 1: len = 8'd3; 2: len = 8'd7; 3: len = 8'd15; default: len = 8'd2;
        endcase
      end else len = 8'($urandom_range(0, 15));
      addr = 32'($urandom_range(0, DEPTH * 4 + 32)) & ~((32'd1 << size) - 32'd1);
      for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      widv = ($urandom_range(0, 9) == 0) ? ~id : id;
      wl   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, int'(len) + 1) : int'(len);
      do_write(id, addr, len, size, burst, wl, widv, $urandom_range(0, 3));
      do_read(8'($urandom), addr, len, size, burst, $urandom_range(0, 2));
    end

    repeat (5) @(posedge aclk);
    #1;
    chk("bq_drained", 64'(bq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

Parametrised AXI slave memory responder. It terminates all five AXI channels of the master interface and backs them with a word-addressed, byte-strobed register array. It supports FIXED, INCR and WRAP bursts of up to 256 beats, with independent read and write engines. It is the synthesizable DUT/reference slave that the master agent drives in the environment, replacing the fixed-width signal bundle with configurable address, data, ID and depth.

## Interface

**Parameters**
- ADDR_WIDTH, 32 — byte address width.
- DATA_WIDTH, 32 — data bus width; power of two, 8..1024.
- ID_WIDTH, 8 — width of awid/wid/bid/arid/rid.
- MEM_DEPTH, 1024 — number of DATA_WIDTH words; NB = DATA_WIDTH/8; word index = addr >> log2(NB).

**Ports**
- aclk  in  1  sole clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address channel.
- awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  ID_WIDTH/DATA_WIDTH/NB/1/1  write data channel.
- wready  out  1
- bid/bresp/bvalid  out  ID_WIDTH/2/1  write response; bready in 1.
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  read address channel.
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; rready in 1.

## Operation

**Reset**
- While aresetn=0, both FSMs go to IDLE.
- awready=1, arready=1; wready, bvalid, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
- Memory contents are not reset.
- Reset mid-burst abandons the burst. Beats already written stay written. No response is issued.

**Write FSM (W_IDLE → W_DATA → W_RESP → W_IDLE)**
- W_IDLE: awready=1, wready=0. On awvalid&&awready, latch id, addr, len, size and burst; clear the error flag; beat counter = 0.
- W_DATA: awready=0, wready=1. Each wvalid&&wready writes byte lanes where wstrb[i]=1 to mem[word index], then advances the address.
- An error is flagged, and the beat is not written, if any of these holds:
  - word index ≥ MEM_DEPTH;
  - wid ≠ latched id;
  - the burst is illegal (see below).
- Leave W_DATA on whichever comes first: a beat with wlast=1, or beat counter == len.
  - If these two do not coincide (early or missing wlast), flag an error.
- W_RESP: bvalid=1, bid = latched id, bresp = 2'b10 (SLVERR) if error else 2'b00 (OKAY). Hold until bready, then go to W_IDLE.

**Read FSM (R_IDLE → R_DATA → R_IDLE)**
- R_IDLE: arready=1. On the handshake, latch fields and load beat 0 data into rdata.
- R_DATA: arready=0, rvalid=1, rid = latched id, rlast = (counter == len).
- rresp: SLVERR with rdata=0 for an out-of-range beat or illegal burst; else OKAY.
- On rvalid&&rready, advance and load the next beat. If rlast is set, go to R_IDLE.

**Illegal bursts** (whole burst is SLVERR; no memory writes; reads return 0)
- burst = 2'b11;
- size > log2(NB);
- WRAP with len ∉ {1,3,7,15}.

**Address update**
- bytes = 1 << size.
- FIXED: address unchanged.
- INCR: next = (addr & ~(bytes-1)) + bytes. Width is ADDR_WIDTH; overflow wraps modulo 2^ADDR_WIDTH.
- WRAP: span = (len+1)*bytes; base = addr & ~(span-1); next = base | ((addr + bytes) & (span-1)).
- Narrow transfers use the lane strobes from the master unmodified. Read data is always the full word.

## Timing

- awready and arready deassert the cycle after their handshake. They reassert the cycle after the B handshake or the final R handshake. The two channel pairs are fully independent.
- Write: wready is high 1 cycle after AW handshake. bvalid is high 1 cycle after the last W beat.
- Read: rvalid is high 1 cycle after AR handshake. Back-to-back beats are produced when rready is held high.
- Outputs never drop while valid and not accepted. bid, bresp, rid, rdata, rresp and rlast are stable until the handshake.
- Same-cycle write and read-fetch to the same word: the read returns the pre-write value.
- Simultaneous awvalid and arvalid: both are accepted in the same cycle.

## Test plan

- **INCR write then read:** AW addr 0x10, len 3, size 2, data 0xA0..0xA3, full strobes.
  - Required: bresp OKAY; AR returns 0xA0..0xA3; rlast on beat 3.
- **WRAP:** AW addr 0x18, len 3, size 2.
  - Required: words written at 0x18, 0x1C, 0x10, 0x14; readback matches.
- **Strobes and FIXED:** 0x11223344 at 0x0, then FIXED len 1 with wstrb 4'b0001 and 4'b1000, data 0xFFFFFFFF.
  - Required: readback 0xFF2233FF.
- **Errors:** each of addr = MEM_DEPTH*NB, burst 2'b11, and early wlast on beat 1 of len 3.
  - Required: bresp SLVERR; affected words unchanged.
- **Backpressure:** rready toggles 1/0 and bready delayed 5 cycles.
  - Required: data, rlast and bresp held stable; no beat lost or duplicated.
- **Reset mid-read:** aresetn low at beat 2 of len 7.
  - Required: rvalid=0 immediately; arready=1; a following read of len 0 completes OKAY.
